// File: rtl/aer_in_rx_if.sv
// AER receive-side bundle: sender REQ/ACK/ADDR plus the downstream valid/ready event port.
// The slave modport is the receiver; master is the environment driving it.
interface aer_in_rx_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] AERIN_ADDR;
  logic              AERIN_REQ;
  logic              AERIN_ACK;
  logic [ADDR_W-1:0] EVT_ADDR;
  logic              EVT_VALID;
  logic              EVT_READY;

  modport master (
    output AERIN_ADDR, AERIN_REQ, EVT_READY,
    input  AERIN_ACK, EVT_ADDR, EVT_VALID
  );

  modport slave (
    input  AERIN_ADDR, AERIN_REQ, EVT_READY,
    output AERIN_ACK, EVT_ADDR, EVT_VALID
  );
endinterface

// File: rtl/aer_in_rx.sv
// aer_in_rx: receive end of a 4-phase AER REQ/ACK link. REQ is double-synchronised,
// addresses are queued in a show-ahead FIFO, and ACK is withheld while no slot is free.
module aer_in_rx #(
  parameter int IMAGE_SIZE      = 256,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int FIFO_DEPTH      = 4,
  parameter int CNT_BITS        = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  aer_in_rx_if.slave                  aer,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL,
  output logic                        FIFO_FULL,
  output logic [CNT_BITS-1:0]         EVT_TOTAL
);
  localparam int ADDR_W = IMAGE_SIZE_BITS + 2;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;

  typedef enum logic {WAIT_REQ = 1'b0, WAIT_REL = 1'b1} state_t;

  state_t              state_r;
  logic                req_s1_r;
  logic                req_s_r;
  logic                ack_r;
  logic                valid_r;
  logic                full_r;
  logic [LVL_W-1:0]    level_r;
  logic [LVL_W-1:0]    level_nxt_s;
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [ADDR_W-1:0]   mem_r [FIFO_DEPTH];
  logic [CNT_BITS-1:0] total_r;
  logic                pop_s;
  logic                push_ok_s;
  logic                push_s;

  assign aer.AERIN_ACK = ack_r;
  assign aer.EVT_VALID = valid_r;
  assign aer.EVT_ADDR  = mem_r[rd_ptr_r];
  assign FIFO_LEVEL    = level_r;
  assign FIFO_FULL     = full_r;
  assign EVT_TOTAL     = total_r;

  // Push/pop decode; a pop at a full FIFO frees the slot for a push on the same edge
  always_comb begin
    pop_s       = valid_r & aer.EVT_READY;
    push_ok_s   = ~full_r | pop_s;
    push_s      = (state_r == WAIT_REQ) & req_s_r & push_ok_s;
    level_nxt_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_W'(1);
      2'b01:   level_nxt_s = level_r - LVL_W'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // Two-flop synchroniser for the asynchronous request
  always_ff @(posedge CLK) begin
    if (RST) begin
      req_s1_r <= 1'b0;
      req_s_r  <= 1'b0;
    end else begin
      req_s1_r <= aer.AERIN_REQ;
      req_s_r  <= req_s1_r;
    end
  end

  // Handshake FSM with registered ACK and saturating capture counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= WAIT_REQ;
      ack_r   <= 1'b0;
      total_r <= '0;
    end else begin
      case (state_r)
        WAIT_REQ: begin
          if (push_s) begin
            ack_r   <= 1'b1;
            state_r <= WAIT_REL;
            if (total_r != '1) begin
              total_r <= total_r + CNT_BITS'(1);
            end
          end
        end
        WAIT_REL: begin
          if (!req_s_r) begin
            ack_r   <= 1'b0;
            state_r <= WAIT_REQ;
          end
        end
        default: begin
          ack_r   <= 1'b0;
          state_r <= WAIT_REQ;
        end
      endcase
    end
  end

  // Circular event buffer; ADDR is sampled raw as it has been stable for two cycles by now
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      valid_r  <= 1'b0;
      full_r   <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= aer.AERIN_ADDR;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      level_r <= level_nxt_s;
      valid_r <= (level_nxt_s != '0);
      full_r  <= (level_nxt_s == LVL_W'(FIFO_DEPTH));
    end
  end
endmodule
